// File: rtl/ahb2apb_bridge_if.sv
// Signal bundle for ahb2apb_bridge: AHB-Lite slave side plus APB3 master side.
// The slave modport is the bridge's view; master is the system/peripheral view.
interface ahb2apb_bridge_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              hselx;
    logic [31:0]       haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [31:0]       hwdata;
    logic              hready;
    logic [1:0]        hresp;
    logic [31:0]       hrdata;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport slave (
        input  hselx, haddr, hwrite, htrans, hsize, hburst, hwdata,
        input  prdata, pready, pslverr,
        output hready, hresp, hrdata,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport master (
        output hselx, haddr, hwrite, htrans, hsize, hburst, hwdata,
        output prdata, pready, pslverr,
        input  hready, hresp, hrdata,
        input  paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB transfer per accepted AHB beat,
// registered wait states, two-cycle ERROR for pslverr/unsupported size/timeout.
module ahb2apb_bridge #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               hclk,
    input  logic               hreset_n,
    ahb2apb_bridge_if.slave    bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_e;

    state_e            state_q,   state_d;
    logic              hready_q,  hready_d;
    logic [1:0]        hresp_q,   hresp_d;
    logic [31:0]       hrdata_q,  hrdata_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [ADDR_W-1:0] paddr_q,   paddr_d;
    logic              psel_q,    psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q,  pwrite_d;
    logic [31:0]       pwdata_q,  pwdata_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic accept;
    logic timeout_hit;
    logic unused_ok;

    assign unused_ok   = ^{bus.haddr, bus.htrans, bus.hburst};
    assign accept      = bus.hselx && bus.htrans[1] && hready_q;
    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

    always_comb begin
        state_d   = state_q;
        hready_d  = hready_q;
        hresp_d   = hresp_q;
        hrdata_d  = hrdata_q;
        addr_d    = addr_q;
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            // ERR2 is a completion cycle, so it samples the next address phase like IDLE
            IDLE, ERR2: begin
                if (accept) begin
                    addr_d   = bus.haddr[ADDR_W-1:0];
                    hready_d = 1'b0;
                    if (bus.hsize > 3'd2) begin
                        state_d = ERR1;
                        hresp_d = HRESP_ERROR;
                    end else if (bus.hwrite) begin
                        state_d = WDATA;
                        hresp_d = HRESP_OKAY;
                    end else begin
                        state_d  = SETUP;
                        hresp_d  = HRESP_OKAY;
                        paddr_d  = bus.haddr[ADDR_W-1:0];
                        pwrite_d = 1'b0;
                        psel_d   = 1'b1;
                    end
                end else begin
                    state_d  = IDLE;
                    hready_d = 1'b1;
                    hresp_d  = HRESP_OKAY;
                end
            end
            WDATA: begin
                state_d  = SETUP;
                pwdata_d = bus.hwdata;
                paddr_d  = addr_q;
                pwrite_d = 1'b1;
                psel_d   = 1'b1;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (bus.pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (bus.pslverr) begin
                        state_d = ERR1;
                        hresp_d = HRESP_ERROR;
                    end else begin
                        state_d  = IDLE;
                        hready_d = 1'b1;
                        hresp_d  = HRESP_OKAY;
                        if (!pwrite_q) hrdata_d = bus.prdata;
                    end
                end else if (timeout_hit) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = ERR1;
                    hresp_d   = HRESP_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR1: begin
                state_d  = ERR2;
                hready_d = 1'b1;
                hresp_d  = HRESP_ERROR;
            end
            default: begin
                state_d  = IDLE;
                hready_d = 1'b1;
                hresp_d  = HRESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= IDLE;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
            hrdata_q  <= '0;
            addr_q    <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            hrdata_q  <= hrdata_d;
            addr_q    <= addr_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.hready  = hready_q;
    assign bus.hresp   = hresp_q;
    assign bus.hrdata  = hrdata_q;
    assign bus.paddr   = paddr_q;
    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.pwdata  = pwdata_q;
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Randomized bench for ahb2apb_bridge: transfer-level reference model predicts
// wait states, response, read data and APB setup fields for each AHB beat.
module tb_ahb2apb_bridge;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned BUDGET  = 20000;

    logic hclk     = 1'b0;
    logic hreset_n = 1'b0;

    ahb2apb_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    ahb2apb_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .hclk    (hclk),
        .hreset_n(hreset_n),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int unsigned waits;   // pready=0 cycles before pready=1 in ACCESS
        logic        err;     // pslverr together with pready
        logic [31:0] rdata;
        int unsigned gap;     // idle cycles before the address phase
    } xfer_t;

    xfer_t       q[$];
    xfer_t       cur;
    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_hrdata;
    logic [31:0] last_pwdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wd, input int unsigned waits, input logic err,
                                input logic [31:0] rd, input int unsigned gap);
        xfer_t t;
        t.wr = wr; t.addr = addr; t.size = size; t.wdata = wd;
        t.waits = waits; t.err = err; t.rdata = rd; t.gap = gap;
        q.push_back(t);
    endfunction

    initial begin
        logic              active;
        int unsigned       cyc, dcyc, low, errlow, psel_cnt, pen_cnt, drift;
        logic [ADDR_W-1:0] s_addr;
        logic              s_wr;
        logic [31:0]       s_wdata;
        logic              size_err, tmo, is_err;
        int unsigned       acc_exp, low_exp;
        logic [2:0]        rsize;
        int unsigned       w, rwaits;

        bus.hselx = 1'b0; bus.haddr = '0; bus.hwrite = 1'b0; bus.htrans = 2'b00;
        bus.hsize = 3'b000; bus.hburst = 3'b000; bus.hwdata = '0;
        bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        exp_hrdata = '0;
        last_pwdata = '0;

        repeat (3) @(negedge hclk);
        chk("rst_hready",  32'(bus.hready),  32'd1);
        chk("rst_hresp",   32'(bus.hresp),   32'd0);
        chk("rst_hrdata",  bus.hrdata,       32'd0);
        chk("rst_psel",    32'(bus.psel),    32'd0);
        chk("rst_penable", 32'(bus.penable), 32'd0);
        chk("rst_pwrite",  32'(bus.pwrite),  32'd0);
        chk("rst_paddr",   32'(bus.paddr),   32'd0);
        chk("rst_pwdata",  bus.pwdata,       32'd0);
        hreset_n = 1'b1;

        add(1'b0, 32'h0000_0010, 3'd2, 32'h0,          0,  1'b0, 32'hCAFE_F00D, 0);
        add(1'b1, 32'h0000_0024, 3'd2, 32'h1234_5678,  3,  1'b0, 32'h0,         1);
        add(1'b0, 32'h0000_0030, 3'd2, 32'h0,          0,  1'b1, 32'hDEAD_BEEF, 1);
        add(1'b0, 32'h0000_0034, 3'd3, 32'h0,          0,  1'b0, 32'h0,         1);
        add(1'b0, 32'h0000_0038, 3'd2, 32'h0,          20, 1'b0, 32'h0,         1);
        add(1'b0, 32'h0000_003C, 3'd1, 32'h0,          0,  1'b0, 32'h5555_AAAA, 0);
        add(1'b0, 32'h0000_0040, 3'd0, 32'h0,          15, 1'b0, 32'h0F0F_0F0F, 1);
        add(1'b1, 32'h0000_0010, 3'd2, 32'hA5A5_5A5A,  0,  1'b0, 32'h0,         1);
        add(1'b0, 32'h0000_0010, 3'd2, 32'h0,          0,  1'b0, 32'hA5A5_5A5A, 0);
        for (int i = 0; i < 120; i++) begin
            rsize  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            w      = $urandom_range(0, 9);
            rwaits = (w < 6) ? $urandom_range(0, 3) : (w < 8) ? $urandom_range(4, 8) : $urandom_range(14, 18);
            add(1'($urandom_range(0, 1)), $urandom, rsize, $urandom, rwaits,
                ($urandom_range(0, 5) == 0), $urandom,
                ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
        end

        active = 1'b0;
        cyc = 0; dcyc = 0; low = 0; errlow = 0; psel_cnt = 0; pen_cnt = 0; drift = 0;
        s_addr = '0; s_wr = 1'b0; s_wdata = '0;
        while ((q.size() > 0 || active) && cyc < BUDGET) begin
            @(negedge hclk);
            cyc++;
            if (active) begin
                dcyc++;
                if (bus.psel) begin
                    psel_cnt++;
                    if (bus.penable) pen_cnt++;
                    if (psel_cnt == 1) begin
                        s_addr = bus.paddr; s_wr = bus.pwrite; s_wdata = bus.pwdata;
                    end else if (bus.paddr !== s_addr || bus.pwrite !== s_wr || bus.pwdata !== s_wdata) begin
                        drift++;
                    end
                end
                if (!bus.hready) begin
                    low++;
                    if (bus.hresp == 2'b01) errlow++;
                end else begin
                    size_err = (cur.size > 3'd2);
                    tmo      = !size_err && (cur.waits >= TIMEOUT);
                    is_err   = size_err || tmo || cur.err;
                    acc_exp  = size_err ? 0 : (tmo ? TIMEOUT : cur.waits + 1);
                    low_exp  = size_err ? 1 : (cur.wr ? 2 : 1) + acc_exp + (is_err ? 1 : 0);
                    if (!is_err && !cur.wr) exp_hrdata = cur.rdata;
                    chk("wait_states", low, low_exp);
                    chk("hresp_done",  32'(bus.hresp), is_err ? 32'd1 : 32'd0);
                    chk("err_cycles",  errlow, is_err ? 32'd1 : 32'd0);
                    chk("hrdata",      bus.hrdata, exp_hrdata);
                    chk("psel_cycles", psel_cnt, size_err ? 32'd0 : acc_exp + 1);
                    chk("pen_cycles",  pen_cnt, acc_exp);
                    if (!size_err) begin
                        if (cur.wr) last_pwdata = cur.wdata;
                        chk("paddr",     32'(s_addr), 32'(cur.addr[ADDR_W-1:0]));
                        chk("pwrite",    32'(s_wr), 32'(cur.wr));
                        chk("pwdata",    s_wdata, last_pwdata);
                        chk("apb_hold",  drift, 32'd0);
                    end
                    active = 1'b0;
                end
                if (active && dcyc > 60) begin
                    chk("stall", dcyc, 32'd60);
                    active = 1'b0;
                end
            end else begin
                chk("idle_hready", 32'(bus.hready), 32'd1);
                chk("idle_psel",   32'(bus.psel),   32'd0);
            end

            // APB slave: pready on access cycle waits+1, random noise elsewhere
            if (active && bus.psel && bus.penable && pen_cnt == cur.waits + 1) begin
                bus.pready  = 1'b1;
                bus.pslverr = cur.err;
                bus.prdata  = cur.rdata;
            end else begin
                bus.pready  = (active && bus.psel) ? 1'b0 : 1'($urandom_range(0, 1));
                bus.pslverr = 1'($urandom_range(0, 1));
                bus.prdata  = $urandom;
            end

            if (!active && bus.hready && q.size() > 0 && q[0].gap == 0) begin
                cur = q.pop_front();
                active = 1'b1;
                dcyc = 0; low = 0; errlow = 0; psel_cnt = 0; pen_cnt = 0; drift = 0;
                bus.hselx  = 1'b1;
                bus.htrans = 2'($urandom_range(2, 3));
                bus.haddr  = cur.addr;
                bus.hwrite = cur.wr;
                bus.hsize  = cur.size;
                bus.hburst = 3'($urandom_range(0, 7));
                bus.hwdata = $urandom;
            end else begin
                if (!active && q.size() > 0 && q[0].gap > 0) q[0].gap--;
                if ($urandom_range(0, 1) == 0) begin
                    bus.hselx  = 1'b0;
                    bus.htrans = 2'($urandom_range(0, 3));
                end else begin
                    bus.hselx  = 1'b1;
                    bus.htrans = {1'b0, 1'($urandom_range(0, 1))};
                end
                bus.haddr  = $urandom;
                bus.hwrite = 1'($urandom_range(0, 1));
                bus.hsize  = 3'($urandom_range(0, 7));
                bus.hwdata = (active && cur.wr && dcyc == 1) ? cur.wdata : $urandom;
            end
        end
        chk("drained", q.size(), 32'd0);
        chk("finished", 32'(active), 32'd0);

        @(negedge hclk);
        bus.hselx = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.hsize = 3'd2;
        bus.haddr = 32'h0000_0044; bus.pready = 1'b0; bus.pslverr = 1'b0;
        @(negedge hclk);
        bus.hselx = 1'b0; bus.htrans = 2'b00;
        chk("rst_setup_psel", 32'(bus.psel), 32'd1);
        @(negedge hclk);
        chk("rst_access_pen", 32'(bus.penable), 32'd1);
        hreset_n = 1'b0;
        #1;
        chk("arst_psel",    32'(bus.psel),    32'd0);
        chk("arst_penable", 32'(bus.penable), 32'd0);
        chk("arst_hready",  32'(bus.hready),  32'd1);
        chk("arst_hresp",   32'(bus.hresp),   32'd0);
        chk("arst_hrdata",  bus.hrdata,       32'd0);
        chk("arst_paddr",   32'(bus.paddr),   32'd0);
        @(negedge hclk);
        hreset_n = 1'b1;
        @(negedge hclk);
        chk("post_rst_hready", 32'(bus.hready), 32'd1);
        chk("post_rst_psel",   32'(bus.psel),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

AHB-to-APB bridge: an AHB-Lite slave on the system bus that converts each accepted AHB transfer into one APB3 transfer on a single downstream APB peripheral. It sits downstream of the AHB interconnect and upstream of APB register blocks, taking the same `hclk`/`hreset_n` and AHB signal set as our AHB slaves. Each transfer is handled on its own, with no buffering. The bridge adds wait states, maps APB errors onto the AHB two-cycle ERROR response, and aborts stalled APB accesses via a timeout.

## Interface
Parameters:
- `ADDR_W`, default 16: APB address width; `paddr = haddr[ADDR_W-1:0]`.
- `TIMEOUT`, default 16: max ACCESS cycles waiting for `pready`; 0 disables the timeout.

Ports:
- `hclk`  in  1  clock, all logic on rising edge.
- `hreset_n`  in  1  reset, asynchronous, active-low.
- `hselx`  in  1  slave select.
- `haddr`  in  32  AHB address.
- `hwrite`  in  1  1 = write.
- `htrans`  in  2  00 idle, 01 busy, 10 nonseq, 11 seq.
- `hsize`  in  3  000 byte, 001 half, 010 word, others unsupported.
- `hburst`  in  3  accepted, ignored; each beat is converted independently.
- `hwdata`  in  32  write data, valid in the data phase.
- `hready`  out  1  registered; 1 = current data phase completes.
- `hresp`  out  2  00 OKAY, 01 ERROR; 10/11 never driven.
- `hrdata`  out  32  read data, registered.
- `paddr`  out  ADDR_W  APB address.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `pwdata`  out  32  APB write data.
- `prdata`  in  32  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB slave error.

## Operation
- **Accept condition.** A transfer is accepted on an edge where `hselx && htrans[1] && hready`. On accept, latch `haddr[ADDR_W-1:0]`, `hwrite` and `hsize`.
- **IDLE/BUSY or unselected.** No state change; `hready` stays 1 and `hresp` stays OKAY.
- **States:** IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- **IDLE** (`hready`=1, `hresp`=00):
  - accepted with `hsize`>2: go to ERR1; no APB access.
  - accepted read: go to SETUP.
  - accepted write: go to WDATA.
  - `hready` drops to 0 on the accept edge.
- **WDATA** (`hready`=0): capture `hwdata` into `pwdata`, then go to SETUP.
- **SETUP:** `psel`=1, `penable`=0; `paddr`/`pwrite` from the latch. Always go to ACCESS.
- **ACCESS:** `psel`=1, `penable`=1; timeout counter increments each cycle.
  - `pready`=1 and `pslverr`=0: go to IDLE, `hready`<=1, `hresp` OKAY. For a read, `hrdata`<=`prdata`.
  - `pready`=1 and `pslverr`=1: go to ERR1. `hrdata` unchanged.
  - `TIMEOUT`!=0, counter reaches `TIMEOUT` with `pready`=0: drop `psel`/`penable`, go to ERR1.
- **ERR1:** `hready`=0, `hresp`=01. Go to ERR2.
- **ERR2:** `hready`=1, `hresp`=01. The next transfer is sampled exactly as in IDLE, so a new transfer may be accepted here; otherwise go to IDLE.
- **Bus deassert.** `psel` and `penable` return to 0 on the edge that leaves ACCESS.
- **Hold values.** `paddr`, `pwrite` and `pwdata` hold their last value outside transfers.
- **Transfer types.** SEQ is treated like NONSEQ. Write byte lanes are not decoded; the full `hwdata` is forwarded.

## Timing
- **Reset values:** `hready`=1, `hresp`=00, `hrdata`=0, `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0; state IDLE; timeout counter 0.
- **Reset mid-transfer:** all outputs return to reset values immediately (asynchronously); the APB transfer is dropped.
- **Read latency.** Accept at edge E0. SETUP after E0, ACCESS after E1. With `pready`=1 in the first ACCESS cycle, `hready`=1 and `hrdata` are valid after E2, giving 2 wait states.
- **Write latency:** one extra WDATA cycle, giving 3 wait states minimum.
- **APB wait states:** each `pready`=0 cycle in ACCESS adds one AHB wait state.
- **Error response:** exactly 2 cycles; `hresp`=01 is held across both cycles.
- **Back-to-back transfers:** the first edge where `hready`=1 (completion) may accept the next transfer, giving zero idle cycles between bridge transfers.
- **Timeout count.** Counted in ACCESS cycles from entry. With `TIMEOUT`=16, the abort happens after 16 ACCESS cycles without `pready`. The counter clears on ACCESS entry.

## Test plan
- Reset with all inputs 0 -> every output at its reset value; `hready`=1.
- Read, `haddr`=0x0000_0010, `prdata`=0xCAFE_F00D, `pready`=1 immediately -> `paddr`=0x0010, `psel` high for 2 cycles; after 2 wait states `hrdata`=0xCAFE_F00D, `hresp`=00.
- Write, `haddr`=0x24, `hwdata`=0x1234_5678, `pready` low for 3 ACCESS cycles -> `pwrite`=1, `pwdata`=0x1234_5678 through SETUP/ACCESS; `hready`=0 for 6 cycles, then 1 with OKAY.
- Read with `pslverr`=1 on `pready` -> ERR1 (`hready`=0, `hresp`=01) then ERR2 (`hready`=1, `hresp`=01); `hrdata` unchanged. Same for `hsize`=3'b011, but with `psel` never asserted.
- `pready` held 0, `TIMEOUT`=16 -> `psel` drops after 16 ACCESS cycles, followed by the two-cycle ERROR response; a new NONSEQ read in the ERR2 cycle is accepted.
- Back-to-back: write 0x10 then read 0x10 with the read address phase on the write's completion cycle -> read SETUP starts the next cycle; `hreset_n` pulsed low in ACCESS -> `psel`/`penable` 0 immediately and `hready`=1.
